// File: rtl/pingpong_buf_ctrl.sv
// rtl/pingpong_buf_ctrl.sv - two-bank ping-pong buffer sequencer with full/empty handshake
// Define PPBUF_STATS_EN to enable the saturating write-stall counter on wr_stall_cnt.
module pingpong_buf_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_vld,
  output logic              wr_rdy,
  output logic              wea,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              save_finish,
  input  logic              rd_en,
  output logic              rea,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_vld,
  output logic              rd_last,
  output logic [1:0]        bank_full,
  output logic [15:0]       wr_stall_cnt
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(DEPTH);

  typedef enum logic {R_IDLE, R_READ} rstate_t;

  rstate_t           state, state_n;
  logic              wr_bank, rd_bank;
  logic [CNT_W-1:0]  wcnt, rcnt;
  logic              wr_done, rd_issue, rd_done, rea_last;
  logic [1:0]        full_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic [RD_LAT-1:0] vld_pipe, last_pipe;

  // Gating with rst keeps every output low while reset is held.
  assign wr_rdy  = !rst && !bank_full[wr_bank];
  assign wea     = wr_vld & wr_rdy;
  assign wr_addr = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(wcnt);
  assign wr_done = wea && (wcnt == LAST_CNT);

  always_comb begin
    state_n   = state;
    rd_issue  = 1'b0;
    rd_done   = 1'b0;
    rd_addr_n = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rcnt);
    case (state)
      R_IDLE: if (bank_full[rd_bank] && rd_en) state_n = R_READ;
      R_READ: begin
        if (rd_en) begin
          rd_issue = 1'b1;
          if (rcnt == LAST_CNT) begin
            rd_done = 1'b1;
            state_n = R_IDLE;
          end
        end
      end
      default: state_n = R_IDLE;
    endcase
    // A completing write and read always target different banks.
    full_n = bank_full;
    if (wr_done) full_n[wr_bank] = 1'b1;
    if (rd_done) full_n[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= R_IDLE;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wcnt        <= '0;
      rcnt        <= '0;
      bank_full   <= 2'b00;
      save_finish <= 1'b0;
      rea         <= 1'b0;
      rea_last    <= 1'b0;
      rd_addr     <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
    end else begin
      state       <= state_n;
      bank_full   <= full_n;
      save_finish <= wr_done;
      if (wea) wcnt <= wr_done ? '0 : wcnt + 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
      rea      <= rd_issue;
      rea_last <= rd_done;
      if (rd_issue) begin
        rd_addr <= rd_addr_n;
        rcnt    <= rd_done ? '0 : rcnt + 1'b1;
      end
      if (rd_done) rd_bank <= ~rd_bank;
      vld_pipe[0]  <= rea;
      last_pipe[0] <= rea_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign rd_vld  = vld_pipe[RD_LAT-1];
  assign rd_last = last_pipe[RD_LAT-1];

`ifdef PPBUF_STATS_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (wr_vld && !wr_rdy && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
  end
  assign wr_stall_cnt = stall_q;
`else
  assign wr_stall_cnt = '0;
`endif

endmodule
